// File: rtl/subleq_pkg.sv
// subleq_pkg: shared definitions for the SUBLEQ memory-side blocks.
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths
//   MAX_REQ / ID_W          : largest supported requester count and the
//                             requester-id width sized for it
//   rd_tag_t                : one stage of the read-return tracking pipeline
//   lock_state_t            : states of the port-lock FSM
package subleq_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // The tag id is sized for the largest requester count so the typedef can
  // live in the package; smaller arbiters simply leave the upper bits zero.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority one-hot picker.
//   req : per-requester request vector
//   ptr : index that has highest priority this cycle
//   gnt : one-hot grant (or zero), first set req at ptr, ptr+1, ... mod N
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Walk the requesters starting at ptr and stop at the first active one.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between NUM_REQ requesters.
//   clock, rst_n          : clock and asynchronous active-low reset
//   req/we/lock           : per-requester request, write strobe, lock-after
//   addr/wdata            : packed per-requester address and write data
//   gnt                   : one-hot grant, transfer when req[i]&gnt[i]
//   rvalid/rdata          : read return pulse for the issuing requester
//   lock_err              : pulse after a lock was released by timeout
//   mem_*                 : single-port interface towards the memory
// Round-robin grant, optional locking for atomic sequences with an idle
// timeout, and a fixed-latency pipeline that routes read data back.
module mem_port_arbiter
  import subleq_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LAT     = 2,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      lock_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_re,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  lock_state_t        state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   g;
  logic [CNT_W-1:0]   idle_cnt;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] eligible;
  logic               accepted;
  logic               sel_we;
  logic               sel_lock;
  rd_tag_t            pipe [READ_LAT];

  // While locked only the owner may compete; nothing is granted in reset.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (owner == PTR_W'(i));
    end
    if (!rst_n) begin
      eligible = '0;
    end else if (state == LOCKED) begin
      eligible = req & owner_mask;
    end else begin
      eligible = req;
    end
  end

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req (eligible),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Encode the grant and steer the winner's fields onto the memory port.
  always_comb begin
    g         = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g         = PTR_W'(i);
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accepted = |gnt;
  assign sel_we   = |(gnt & we);
  assign sel_lock = |(gnt & lock);
  assign mem_re   = accepted & ~sel_we;
  assign mem_we   = accepted & sel_we;

  // The pointer keeps rotating under lock so fairness resumes after unlock.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accepted) begin
      ptr <= (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end
  end

  // Lock FSM: an owner transfer always wins over the timeout in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      owner    <= '0;
      idle_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state)
        UNLOCKED: begin
          if (accepted && sel_lock) begin
            state    <= LOCKED;
            owner    <= g;
            idle_cnt <= '0;
          end
        end
        LOCKED: begin
          if (accepted) begin
            idle_cnt <= '0;
            if (!sel_lock) begin
              state <= UNLOCKED;
            end
          end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state    <= UNLOCKED;
            idle_cnt <= '0;
            lock_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  // Read tracking: one tag per accepted read, emerging READ_LAT cycles later.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= mem_re;
      pipe[0].id    <= ID_W'(g);
      for (int i = 1; i < READ_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = pipe[READ_LAT-1].valid && (pipe[READ_LAT-1].id == ID_W'(i));
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter.
// A behavioural model (search order, lock ownership, silent-owner count and a
// queue of expected read returns) predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int LT = 16;

  logic            clock = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            lock_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_re, mem_we;
  logic [DW-1:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .LOCK_TIMEOUT(LT)
  ) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .lock_err(lock_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] initWord(input int i);
    return 32'h0000_0100 + 32'(i) * 32'h0000_0011;
  endfunction

  // Memory the DUT talks to: fixed-latency reads, writes in place.
  logic [DW-1:0] dmem    [16];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) dmem[i] <= initWord(i);
    end else if (mem_we) begin
      dmem[mem_addr[3:0]] <= mem_wdata;
    end
    rd_pipe[0] <= dmem[mem_addr[3:0]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RL-1];

  // Reference model state.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       rq[$];
  logic [DW-1:0] ref_mem [16];
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  int            m_silent;
  bit            m_err_pend;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    rq.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = initWord(i);
    m_ptr      = 0;
    m_locked   = 0;
    m_owner    = 0;
    m_silent   = 0;
    m_err_pend = 0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req[i]  = $urandom_range(1, 0);
      we[i]   = $urandom_range(1, 0);
      lock[i] = ($urandom_range(5, 0) == 0);
      addr[i*AW +: AW]  = $urandom;
      wdata[i*DW +: DW] = $urandom;
    end
    // A locked owner mostly stays silent so timeouts actually happen.
    if (m_locked && ($urandom_range(7, 0) != 0)) req[m_owner] = 1'b0;
  endtask

  // Compare every output against the model, then advance the model by one cycle.
  task automatic checkCycle();
    int            g;
    int            idx;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req[idx] && (!m_locked || idx == m_owner)) g = idx;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    checkOutput("gnt", 64'(gnt), 64'(exp_gnt));
    if (g >= 0) begin
      checkOutput("mem_re", 64'(mem_re), 64'(!we[g]));
      checkOutput("mem_we", 64'(mem_we), 64'(we[g]));
      checkOutput("mem_addr", 64'(mem_addr), 64'(addr[g*AW +: AW]));
      if (we[g]) checkOutput("mem_wdata", 64'(mem_wdata), 64'(wdata[g*DW +: DW]));
    end else begin
      checkOutput("idle_strobes", 64'({mem_re, mem_we}), 64'(0));
      checkOutput("idle_addr", 64'(mem_addr), 64'(0));
    end

    exp_rv = '0;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].id] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
    checkOutput("rvalid", 64'(rvalid), 64'(exp_rv));
    if (exp_rv != '0) checkOutput("rdata", 64'(rdata), 64'(exp_rd));
    checkOutput("lock_err", 64'(lock_err), 64'(m_err_pend));

    m_err_pend = 0;
    if (g >= 0) begin
      if (we[g]) ref_mem[addr[g*AW +: 4]] = wdata[g*DW +: DW];
      else rq.push_back('{due: cyc + RL, id: g, data: ref_mem[addr[g*AW +: 4]]});
      m_ptr = (g + 1) % N;
    end
    if (m_locked) begin
      if (g >= 0) begin
        m_silent = 0;
        if (!lock[g]) m_locked = 0;
      end else if (m_silent + 1 >= LT) begin
        m_locked   = 0;
        m_silent   = 0;
        m_err_pend = 1;
      end else begin
        m_silent++;
      end
    end else if (g >= 0 && lock[g]) begin
      m_locked = 1;
      m_owner  = g;
      m_silent = 0;
    end
    cyc++;
  endtask

  // Reset in the middle of traffic: outputs must be quiet, in-flight reads lost.
  task automatic doReset();
    @(negedge clock);
    rst_n = 1'b0;
    applyStimulus();
    req = '1;
    #1;
    checkOutput("rst_gnt", 64'(gnt), 64'(0));
    checkOutput("rst_strobes", 64'({mem_re, mem_we}), 64'(0));
    checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
    checkOutput("rst_lock_err", 64'(lock_err), 64'(0));
    modelReset();
    repeat (2) @(negedge clock);
    req   = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_order [5];
    rr_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    modelReset();
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_rvalid", 64'(rvalid), 64'(0));
    checkOutput("reset_lock_err", 64'(lock_err), 64'(0));
    rst_n = 1'b1;

    // Everyone requesting, no lock: plain rotation from index 0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      req  = '1;
      we   = '0;
      lock = '0;
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
      end
      #1;
      checkOutput("rr_seq", 64'(gnt), 64'(1) << rr_order[k]);
      checkCycle();
    end

    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 350) doReset();
      @(negedge clock);
      applyStimulus();
      #1;
      checkCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one port of the SUBLEQ dual-port `memory` between N requesters: processor cores, host loader, debug reader. Grants are round-robin. A requester can lock the port to make a read-modify-write sequence atomic, and the lock is released by a timeout if its owner goes quiet. The block tracks in-flight reads and routes each read-valid back to the requester that issued it. It sits between the requester datapaths and `memory`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `READ_LAT`, 2: cycles from `mem_re` to valid `mem_rdata`, 1..4
- `LOCK_TIMEOUT`, 16: idle owner cycles before a forced unlock
- `clock`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester access request
- `we`  in  NUM_REQ  1 = write, 0 = read
- `lock`  in  NUM_REQ  hold the port after this access
- `addr`  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
- `wdata`  in  NUM_REQ*DATA_W  packed like `addr`
- `gnt`  out  NUM_REQ  one-hot or zero; access accepted when `req[i]&gnt[i]`
- `rvalid`  out  NUM_REQ  one-cycle pulse; `rdata` is valid for requester i
- `rdata`  out  DATA_W  broadcast read data
- `lock_err`  out  1  one-cycle pulse on a timeout unlock
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  to `memory`
- `mem_re`, `mem_we`  out  1  to `memory`
- `mem_rdata`  in  DATA_W  from `memory`

## Operation
- **Grant**
  - `gnt` is combinational from `req`, the priority pointer `ptr` and the lock state.
  - At most one bit of `gnt` is set.
  - A `gnt` bit is never set without its `req` bit.
- **Unlocked search order**
  - Search starts at `ptr`: `ptr`, `ptr+1`, …, wrapping modulo NUM_REQ.
  - The first set `req` wins.
- **Locked**
  - Only `lock_owner` can be granted; all other requesters stall.
  - The lock persists when the owner drops `req`.
- **Mux**
  - `mem_addr`/`mem_wdata` carry the granted requester's fields; they are 0 when nothing is granted.
  - `mem_re = |gnt & ~we[g]`.
  - `mem_we = |gnt & we[g]`.
- **Pointer update**
  - On an accepted transfer by g, `ptr <= (g+1) mod NUM_REQ`.
  - The update also happens under lock; it takes effect after unlock.
- **Lock**
  - Set: an accepted transfer with `lock[g]=1` sets `lock_active` and `lock_owner=g`.
  - Release: an accepted transfer by the owner with `lock=0` clears `lock_active` after that transfer.
- **Lock timeout**
  - Counter `idle_cnt` increments each cycle while `lock_active` and the owner is not transferring.
  - `idle_cnt` resets to 0 on any owner transfer.
  - When `idle_cnt == LOCK_TIMEOUT-1` and the owner is still idle: clear the lock, pulse `lock_err` the next cycle, zero `idle_cnt`.
- **Read tracking**
  - Shift pipeline of depth READ_LAT carrying `{valid, id}`.
  - A stage is loaded on each accepted read.
  - At the tail, `rvalid[id]` is asserted and `rdata = mem_rdata`.
  - Writes create no entry.
- Back-to-back reads from different requesters each return in order, one per cycle.

## Timing
- Grant is a 0-cycle decision; the memory strobes appear in the same cycle as acceptance.
- A read accepted in cycle t gives `rvalid` in cycle t+READ_LAT.
- Throughput is one access per cycle.
- Reset (`rst_n=0`, asynchronous):
  - `ptr=0`, lock cleared, `idle_cnt=0`, pipeline invalid.
  - `rvalid=0`, `lock_err=0`; `gnt`/`mem_re`/`mem_we` are 0 while reset is held.
  - Reads in flight are dropped and never return.
- Simultaneous events:
  - Owner transfer with `lock=0` in the timeout cycle counts as a normal release; no `lock_err`.
  - A new lock may be set in the cycle after any release.

## Structure
- `subleq_pkg`: `ADDR_W`/`DATA_W` defaults and typedef `rd_tag_t {logic valid; logic [$clog2(NUM_REQ)-1:0] id;}`.
- Sub-module `rr_pick`: combinational rotate-priority one-hot picker (`req`, `ptr` → `gnt`).
- The lock FSM (UNLOCKED, LOCKED) and the read pipeline live in the top module.

## Test plan
- NUM_REQ=4, all `req` held, no lock, reset → grant sequence 0,1,2,3,0 on consecutive cycles.
- Read by req 2 at addr 0x10 (memory holds 0x5), READ_LAT=2 → `rvalid[2]` and `rdata=0x5` exactly 2 cycles later; other `rvalid` bits stay 0.
- Req 1 reads with `lock=1` while req 0/3 are active → only 1 is granted until its write with `lock=0`; then 2, 3 or 0 are granted per `ptr=2`.
- Req 1 locks then drops `req` for 16 cycles → `lock_err` pulses once; req 3 is granted the next cycle.
- Reads from 0, then 3, on consecutive cycles → `rvalid[0]`, `rvalid[3]` on consecutive cycles with matching data.
- `rst_n` asserted while 2 reads are in flight → no `rvalid` after deassert; the first grant goes to the lowest active index ≥ 0.
